// File: rtl/dot_acc.sv
// rtl/dot_acc.sv - sums LEN partial dot-product beats into one scalar result.
// Optional saturation and sticky overflow flag when DOT_ACC_SAT_EN is defined.
module dot_acc #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             accept;
    logic             last_beat;

    assign accept    = in_valid && (state_q == ST_ACC);
    assign last_beat = (cnt_q == (len_q - CNT_ONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so no input-to-output comb path.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DOT_ACC_SAT_EN
    logic          ovf_q, ovf_d;
    logic [DW:0]   sum_w;

    assign sum_w = {1'b0, acc_q} + {1'b0, in_data};

    // Once clamped, acc stays all-ones until the next start.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        ovf_d = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    len_d = len;
                    ovf_d = 1'b0;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (sum_w[DW] || ovf_q) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_w[DW-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    len_d = len;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                    acc_d = acc_q + in_data;
                end
            end
            default: ;
        endcase
    end

    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    // acc is untouched outside ACC and start, so the result persists into IDLE.
    assign out_data = acc_q;

endmodule
